// File: rtl/cnn_q_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cnn_q_pkg: shared widths, int4 limit, pixel FSM states, clog2 helper  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package cnn_q_pkg;

  localparam int c_in_w  = 12;
  localparam int c_acc_w = 16;
  localparam int c_out_w = 4;
  localparam int c_q4_max = (1 << (c_out_w - 1)) - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic int q_clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/q_relu_round_sat.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | q_relu_round_sat: ReLU, round-half-up shift and clamp to OUT_W signed |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module q_relu_round_sat #(
  parameter int Y_W   = 17,
  parameter int SHIFT = 3,
  parameter int OUT_W = 4
) (
  input  logic signed [Y_W-1:0]   y,
  output logic        [OUT_W-1:0] q,
  output logic                    sat
);

  localparam logic signed [Y_W:0] c_half = {{Y_W{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [Y_W:0] c_max  = {{(Y_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};

  logic signed [Y_W:0] w_sum;
  logic signed [Y_W:0] w_r;
  logic                w_pos;

  // One extra bit keeps the rounding add from wrapping on the largest positive y.
  assign w_sum = {y[Y_W-1], y} + c_half;
  assign w_r   = w_sum >>> SHIFT;
  assign w_pos = !y[Y_W-1] && (|y);
  assign sat   = w_pos && (w_r > c_max);

  always_comb begin
    q = '0;
    if (sat) begin
      q = c_max[OUT_W-1:0];
    end else if (w_pos) begin
      q = w_r[OUT_W-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_chacc_relu_q4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | conv_chacc_relu_q4: channel accumulate + bias, ReLU, requantise int4 |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module conv_chacc_relu_q4
  import cnn_q_pkg::*;
#(
  parameter int IN_W   = c_in_w,
  parameter int NUM_CH = 4,
  parameter int ACC_W  = c_acc_w,
  parameter int SHIFT  = 3,
  parameter int OUT_W  = c_out_w,
  localparam int CH_W  = (q_clog2(NUM_CH) < 1) ? 1 : q_clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [OUT_W-1:0] out_data,
  output logic                    out_sat,
  output logic        [CH_W-1:0]  ch_idx
);

  generate
    if (ACC_W < IN_W + q_clog2(NUM_CH) + 1) begin : g_bad_acc_w
      $error("conv_chacc_relu_q4: ACC_W too narrow for IN_W and NUM_CH");
    end
    if (NUM_CH < 1 || SHIFT < 1) begin : g_bad_params
      $error("conv_chacc_relu_q4: NUM_CH and SHIFT must be >= 1");
    end
  endgenerate

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic        [CH_W-1:0]  r_ch_idx;
  logic                    r_out_valid;
  logic        [OUT_W-1:0] r_out_data;
  logic                    r_out_sat;

  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W:0]   w_in_ext;
  logic signed [ACC_W:0]   w_y;
  logic        [OUT_W-1:0] w_q;
  logic                    w_q_sat;

  assign in_ready  = (r_state != ST_OUT);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == ST_IDLE) ? (NUM_CH == 1)
                                          : (r_ch_idx == CH_W'(NUM_CH - 1));
  // Bias enters on the first beat so the accumulator never needs a separate load cycle.
  assign w_base    = (r_state == ST_IDLE) ? bias : r_acc;
  assign w_in_ext  = {{(ACC_W + 1 - IN_W){in_data[IN_W-1]}}, in_data};
  assign w_y       = {w_base[ACC_W-1], w_base} + w_in_ext;

  q_relu_round_sat #(
    .Y_W   (ACC_W + 1),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_quant (
    .y   (w_y),
    .q   (w_q),
    .sat (w_q_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_last ? ST_OUT : ST_ACC;
      ST_ACC:  if (w_accept && w_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_ch_idx    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else if (flush) begin
      r_ch_idx    <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc <= w_y[ACC_W-1:0];
      if (w_last) begin
        r_ch_idx    <= '0;
        r_out_valid <= 1'b1;
        r_out_data  <= w_q;
        r_out_sat   <= w_q_sat;
      end else begin
        r_ch_idx <= r_ch_idx + CH_W'(1);
      end
    end else if (r_state == ST_OUT && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign ch_idx    = r_ch_idx;

endmodule
`default_nettype wire

// File: tb/tb_conv_chacc_relu_q4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_conv_chacc_relu_q4: directed + random pixels against integer model |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_conv_chacc_relu_q4;

  localparam int SH = 3;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic signed [15:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic signed [11:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic        [3:0]  out_data;
  logic               out_sat;
  logic        [1:0]  ch_idx;

  int n_tests;
  int n_fail;

  conv_chacc_relu_q4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .ch_idx    (ch_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel value straight from the arithmetic rules: ReLU, round half up, clamp to 7.
  function automatic void ref_q(input int y, output int q, output int s);
    int r;
    r = (y <= 0) ? 0 : ((y + (1 << (SH - 1))) >>> SH);
    q = (r > 7) ? 7 : r;
    s = (r > 7) ? 1 : 0;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pixel(input int b, input int d0, input int d1, input int d2,
                           input int d3, input string tag);
    int dd[4];
    int eq;
    int es;
    dd = '{d0, d1, d2, d3};
    chk({tag, "_rdy"}, int'(in_ready), 1);
    bias = 16'(b);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 12'(dd[i]);
      tick();
    end
    in_valid = 1'b0;
    ref_q(b + d0 + d1 + d2 + d3, eq, es);
    chk({tag, "_valid"}, int'(out_valid), 1);
    chk({tag, "_data"}, int'(out_data), eq);
    chk({tag, "_sat"}, int'(out_sat), es);
    if (out_ready) begin
      tick();
      chk({tag, "_ack"}, int'(out_valid), 0);
    end
  endtask

  initial begin
    int eq;
    int es;
    int b;
    int y;
    int d;
    int waited;
    int exp_ch[8];
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    bias      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_sat", int'(out_sat), 0);
    chk("rst_ch", int'(ch_idx), 0);
    chk("rst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic, bias, ReLU, saturation, negative extreme
    run_pixel(0, 5, 6, 7, 2, "c1");
    run_pixel(-12, 5, 6, 7, 2, "c2a");
    run_pixel(0, -100, 10, 10, 10, "c2b");
    run_pixel(0, 2047, 2047, 2047, 2047, "c3a");
    run_pixel(0, -2048, -2048, -2048, -2048, "c3b");

    // backpressure: held result, no beats consumed
    out_ready = 1'b0;
    run_pixel(0, 10, 10, 10, 10, "c4a");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 12'($urandom_range(0, 4095));
      tick();
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_data", int'(out_data), 5);
      chk("bp_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_ack", int'(out_valid), 0);
    run_pixel(0, 5, 6, 7, 2, "c4b");

    // bubbles: ch_idx tracks accepted beats only
    exp_ch = '{1, 1, 2, 2, 2, 3, 0, 0};
    bias = '0;
    chk("bub_ch0", int'(ch_idx), 0);
    for (int i = 0; i < 7; i++) begin
      in_valid = (i == 0 || i == 2 || i == 5 || i == 6);
      in_data  = (i == 0) ? 12'sd5 : (i == 2) ? 12'sd6 : (i == 5) ? 12'sd7 : 12'sd2;
      tick();
      chk($sformatf("bub_ch%0d", i + 1), int'(ch_idx), exp_ch[i]);
    end
    in_valid = 1'b0;
    chk("bub_valid", int'(out_valid), 1);
    chk("bub_data", int'(out_data), 3);
    tick();

    // asynchronous reset mid-pixel
    bias = 16'sd500;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 12'sd900;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(out_valid), 0);
    chk("arst_data", int'(out_data), 0);
    chk("arst_ch", int'(ch_idx), 0);
    chk("arst_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_pixel(0, 5, 6, 7, 2, "c6a");

    // flush mid-pixel
    bias = 16'sd500;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 12'sd900;
      tick();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    chk("flush_ch", int'(ch_idx), 0);
    chk("flush_data", int'(out_data), 3);
    run_pixel(-12, 5, 6, 7, 2, "c6b");

    // randomized pixels with bubbles and backpressure
    for (int k = 0; k < 40; k++) begin
      b = int'($urandom_range(0, 400)) - 200;
      bias = 16'(b);
      y = b;
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        waited = 0;
        while (!in_ready && waited < 20) begin
          tick();
          waited++;
        end
        if (waited >= 20) chk("rnd_timeout", 1, 0);
        d = int'($urandom_range(0, 4095)) - 2048;
        if ((k % 4) == 0) d = int'($urandom_range(0, 2047));
        y += d;
        in_valid = 1'b1;
        in_data  = 12'(d);
        tick();
        in_valid = 1'b0;
      end
      ref_q(y, eq, es);
      out_ready = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        chk($sformatf("rnd%0d_hold", k), int'(out_data), eq);
        tick();
      end
      chk($sformatf("rnd%0d_valid", k), int'(out_valid), 1);
      chk($sformatf("rnd%0d_data", k), int'(out_data), eq);
      chk($sformatf("rnd%0d_sat", k), int'(out_sat), es);
      out_ready = 1'b1;
      tick();
      chk($sformatf("rnd%0d_ack", k), int'(out_valid), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
